hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding unit for the pipelined MIPS core; it replaces the ad-hoc EXE/MEM comparisons in the ID-stage control.
- Keeps a registered scoreboard of in-flight register writes for DEPTH stages past ID.
- Selects the forwarding source for each ID operand, generates load-use stalls and bubbles, and performs redirect flushes.
- Counts stall cycles for performance debug.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_src_match.sv | 27 ++
 rtl/hazard_scoreboard.sv | 80 ++++++++
 tb/tb_hazard_scoreboard.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, forward-select encoding and MIPS opcode/funct constants.
package hazard_pkg;
  localparam int DST_W = 8;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic             valid;
    logic [DST_W-1:0] dst;
    logic             is_load;
  } sb_entry_t;
  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2b;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] ORI   = 6'h0d;
  localparam logic [5:0] LUI   = 6'h0f;
  localparam logic [5:0] ADDU  = 6'h21;
  localparam logic [5:0] SUBU  = 6'h23;
  function automatic logic entry_ready(input sb_entry_t e, input int k, input int load_lat);
    return !e.is_load || k >= load_lat;
  endfunction
endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: youngest-match search of one ID source over the scoreboard, yielding forward select or hazard.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = 3
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [REG_AW-1:0]     src,
  input  logic                  used,
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);
  // Oldest to youngest, so the last match written (smallest k) wins.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    hazard = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && src != '0 && sb[k-1].valid && sb[k-1].dst == DST_W'(src)) begin
        sel = entry_ready(sb[k-1], k, LOAD_LAT) ? SEL_W'(k) : SEL_W'(FWD_RF);
        hazard = !entry_ready(sb[k-1], k, LOAD_LAT);
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write scoreboard driving ID forwarding selects, load-use stalls, redirect flushes and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_dst,
  input  logic              id_is_load,
  input  logic              id_redirect,
  output logic              pc_wr,
  output logic              ifid_wr,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);
  if (DEPTH < 2 || DEPTH > 7) begin : g_bad_depth
    $error("hazard_scoreboard: DEPTH must be 2..7");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > DEPTH) begin : g_bad_load_lat
    $error("hazard_scoreboard: LOAD_LAT must be 1..DEPTH");
  end
  if ((2 ** SEL_W) <= DEPTH) begin : g_bad_sel_w
    $error("hazard_scoreboard: SEL_W too narrow for DEPTH");
  end
  if (REG_AW > DST_W) begin : g_bad_reg_aw
    $error("hazard_scoreboard: REG_AW exceeds scoreboard dst width");
  end
  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [SEL_W-1:0]      sel_a, sel_b;
  logic                  haz_a, haz_b, stall, go;
  hazard_src_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_a (
    .sb(sb_q), .src(id_rs), .used(id_rs_used), .sel(sel_a), .hazard(haz_a)
  );
  hazard_src_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_b (
    .sb(sb_q), .src(id_rt), .used(id_rt_used), .sel(sel_b), .hazard(haz_b)
  );
  always_comb begin
    stall = rst && id_valid && (haz_a || haz_b);
    go = rst && !stall;
    pc_wr = go;
    ifid_wr = go;
    ifid_flush = go && id_valid && id_redirect;
    idex_bubble = !go || !id_valid;
    fwd_a_sel = go ? sel_a : SEL_W'(FWD_RF);
    fwd_b_sel = go ? sel_b : SEL_W'(FWD_RF);
    stall_cnt = stall_cnt_q;
  end
  // A stalled instruction stays in ID, so stage 1 receives a bubble.
  always_comb begin
    sb_d[0] = '{valid:   id_valid && id_wr_en && id_wr_dst != '0 && !stall,
                dst:     DST_W'(id_wr_dst),
                is_load: id_is_load};
    for (int i = 1; i < DEPTH; i++) sb_d[i] = sb_q[i-1];
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard against an instruction-history model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;
  localparam int DEPTH = 3;
  localparam int LOAD_LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic id_wr_en = 1'b0, id_is_load = 1'b0, id_redirect = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wr_dst = '0;
  logic pc_wr, ifid_wr, ifid_flush, idex_bubble;
  logic [2:0] fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;
  logic s_pc_wr, s_ifid_wr, s_ifid_flush, s_idex_bubble;
  logic [2:0] s_fwd_a_sel, s_fwd_b_sel;
  logic [7:0] s_stall_cnt;
  logic [25:0] obs, exp_v;
  int vectors = 0, miscompares = 0, cnt = 0;
  typedef struct { bit v; int dst; bit ld; } ent_t;
  ent_t hist[$];

  always #5 clk = ~clk;
  assign obs = {pc_wr, ifid_wr, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel, stall_cnt};

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
    .id_is_load(id_is_load), .id_redirect(id_redirect), .pc_wr(pc_wr), .ifid_wr(ifid_wr),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
  );
  hazard_scoreboard #(.CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
    .id_is_load(id_is_load), .id_redirect(id_redirect), .pc_wr(s_pc_wr), .ifid_wr(s_ifid_wr),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .fwd_a_sel(s_fwd_a_sel),
    .fwd_b_sel(s_fwd_b_sel), .stall_cnt(s_stall_cnt)
  );

  // hist[i] is the instruction that left ID i+1 cycles ago.
  function automatic int resolve(input int src, input bit used);
    if (!used || src == 0) return 0;
    foreach (hist[i]) if (hist[i].v && hist[i].dst == src) return (hist[i].ld && i + 1 < LOAD_LAT) ? -1 : i + 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    return id_valid && (resolve(int'(id_rs), id_rs_used) < 0 || resolve(int'(id_rt), id_rt_used) < 0);
  endfunction

  function automatic logic [25:0] model_out();
    int a = resolve(int'(id_rs), id_rs_used);
    int b = resolve(int'(id_rt), id_rt_used);
    logic [15:0] c = cnt > 65535 ? 16'hFFFF : 16'(cnt);
    if (!rst || model_stall()) return {4'b0001, 6'd0, c};
    return {2'b11, id_valid && id_redirect, !id_valid, a < 0 ? 3'd0 : 3'(a), b < 0 ? 3'd0 : 3'(b), c};
  endfunction

  task automatic advance();
    bit r = rst;
    bit st = rst && model_stall();
    ent_t e = '{v: id_valid && id_wr_en && id_wr_dst != 0 && !st, dst: int'(id_wr_dst), ld: id_is_load};
    @(posedge clk);
    if (!r) begin
      hist = {};
      repeat (DEPTH) hist.push_back('{v: 0, dst: 0, ld: 0});
      cnt = 0;
    end else begin
      hist.push_front(e);
      void'(hist.pop_back());
      if (st) cnt++;
    end
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input int rs, input int rt, input int rd, input bit redir = 1'b0);
    id_valid = 1'b1;
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_redirect = redir;
    id_rs_used = op inside {RTYPE, LW, SW, BEQ, ORI};
    id_rt_used = op inside {RTYPE, SW, BEQ};
    id_wr_en = (op == RTYPE && fn inside {ADDU, SUBU}) || op inside {LW, ORI, LUI};
    id_wr_dst = op == RTYPE ? 5'(rd) : 5'(rt);
    id_is_load = op == LW;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    id_valid = 1'b0;
    advance();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    set_instr(LW, 6'h0, 0, 5, 0);
    advance();
    set_instr(RTYPE, SUBU, 5, 1, 6);
    @(negedge clk); exp_v = model_out(); vectors++;
    if (obs !== {4'b0001, 6'd0, 16'd0}) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", obs, {4'b0001, 6'd0, 16'd0}); end
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_model: got %h want %h", obs, exp_v); end
    advance();
    rst = 1'b1;
  endtask

  task automatic test_forward();
    do_reset();
    set_instr(RTYPE, ADDU, 1, 2, 3);
    @(negedge clk); exp_v = model_out(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL fwd_first: got %h want %h", obs, exp_v); end
    advance();
    set_instr(RTYPE, ADDU, 3, 3, 4);
    @(negedge clk); exp_v = model_out(); vectors++;
    if (fwd_a_sel !== 3'd1 || fwd_b_sel !== 3'd1 || pc_wr !== 1'b1) begin
      miscompares++; $display("FAIL fwd_dep: got a=%0d b=%0d pc_wr=%b want a=1 b=1 pc_wr=1", fwd_a_sel, fwd_b_sel, pc_wr);
    end
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL fwd_dep_model: got %h want %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(LW, 6'h0, 0, 5, 0);
    advance();
    set_instr(RTYPE, SUBU, 5, 1, 6);
    @(negedge clk); exp_v = model_out(); vectors++;
    if (pc_wr !== 1'b0 || ifid_wr !== 1'b0 || idex_bubble !== 1'b1) begin
      miscompares++; $display("FAIL load_use_stall: got pc_wr=%b ifid_wr=%b bubble=%b want 0 0 1", pc_wr, ifid_wr, idex_bubble);
    end
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL load_use_model: got %h want %h", obs, exp_v); end
    advance();
    @(negedge clk); exp_v = model_out(); vectors++;
    if (stall_cnt !== 16'd1 || fwd_a_sel !== 3'd2 || pc_wr !== 1'b1) begin
      miscompares++; $display("FAIL load_use_fwd: got cnt=%0d a=%0d pc_wr=%b want cnt=1 a=2 pc_wr=1", stall_cnt, fwd_a_sel, pc_wr);
    end
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL load_use_fwd_model: got %h want %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_r0();
    do_reset();
    set_instr(ORI, 6'h0, 0, 0, 0);
    advance();
    set_instr(RTYPE, ADDU, 0, 0, 7);
    @(negedge clk); exp_v = model_out(); vectors++;
    if (fwd_a_sel !== 3'd0 || fwd_b_sel !== 3'd0 || pc_wr !== 1'b1) begin
      miscompares++; $display("FAIL r0_untracked: got a=%0d b=%0d pc_wr=%b want 0 0 1", fwd_a_sel, fwd_b_sel, pc_wr);
    end
    advance();
  endtask

  task automatic test_youngest();
    do_reset();
    set_instr(ORI, 6'h0, 1, 8, 0);
    advance();
    set_instr(LUI, 6'h0, 0, 8, 0);
    advance();
    set_instr(RTYPE, ADDU, 8, 8, 9);
    @(negedge clk); exp_v = model_out(); vectors++;
    if (fwd_a_sel !== 3'd1 || fwd_b_sel !== 3'd1) begin
      miscompares++; $display("FAIL youngest_wins: got a=%0d b=%0d want 1 1", fwd_a_sel, fwd_b_sel);
    end
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL youngest_model: got %h want %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_branch();
    do_reset();
    set_instr(LW, 6'h0, 0, 2, 0);
    advance();
    set_instr(BEQ, 6'h0, 2, 2, 0, 1'b1);
    @(negedge clk); vectors++;
    if (ifid_flush !== 1'b0 || pc_wr !== 1'b0) begin
      miscompares++; $display("FAIL branch_stall: got flush=%b pc_wr=%b want 0 0", ifid_flush, pc_wr);
    end
    advance();
    @(negedge clk); exp_v = model_out(); vectors++;
    if (ifid_flush !== 1'b1 || fwd_a_sel !== 3'd2 || fwd_b_sel !== 3'd2) begin
      miscompares++; $display("FAIL branch_resolve: got flush=%b a=%0d b=%0d want 1 2 2", ifid_flush, fwd_a_sel, fwd_b_sel);
    end
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL branch_model: got %h want %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_instr(LW, 6'h0, 0, 5, 0);
    advance();
    set_instr(RTYPE, SUBU, 5, 1, 6);
    rst = 1'b0;
    @(negedge clk); vectors++;
    if (pc_wr !== 1'b0 || idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_outputs: got pc_wr=%b bubble=%b flush=%b want 0 1 0", pc_wr, idex_bubble, ifid_flush);
    end
    advance();
    rst = 1'b1;
    @(negedge clk); exp_v = model_out(); vectors++;
    if (fwd_a_sel !== 3'd0 || pc_wr !== 1'b1 || stall_cnt !== 16'd0) begin
      miscompares++; $display("FAIL rst_mid_clear: got a=%0d pc_wr=%b cnt=%0d want 0 1 0", fwd_a_sel, pc_wr, stall_cnt);
    end
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL rst_mid_model: got %h want %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{RTYPE, RTYPE, LW, SW, BEQ, J, ORI, LUI};
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      set_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 1) ? ADDU : SUBU,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) id_valid = 1'b0;
      rst = $urandom_range(0, 49) != 0;
      @(negedge clk); exp_v = model_out(); vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL random[%0d]: got %h want %h", n, obs, exp_v); end
      advance();
    end
    rst = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      set_instr(LW, 6'h0, 0, 5, 0);
      advance();
      set_instr(RTYPE, SUBU, 5, 5, 6);
      @(negedge clk); exp_v = model_out(); vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL sat_loop[%0d]: got %h want %h", n, obs, exp_v); end
      advance();
    end
    id_valid = 1'b0;
    @(negedge clk); vectors++;
    if (s_stall_cnt !== 8'hFF || stall_cnt !== 16'd300) begin
      miscompares++; $display("FAIL saturate: got narrow=%h wide=%0d want narrow=ff wide=300", s_stall_cnt, stall_cnt);
    end
    advance();
  endtask

  initial begin
    repeat (DEPTH) hist.push_back('{v: 0, dst: 0, ld: 0});
    test_reset();
    test_forward();
    test_load_use();
    test_r0();
    test_youngest();
    test_branch();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
